// File: rtl/spi_regfile_rw.sv
// rtl/spi_regfile_rw.sv - SPI mode-0 register file with read-back, write strobes and frame-error pulse
module spi_regfile_rw #(
    parameter int                NUM_REGS  = 8,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         COPI,
    input  logic                         SCLK,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    // Count value just before the edge that completes the address field.
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic r_copi_s1, r_copi_s2;
    logic r_ncs_s1, r_ncs_s2, r_ncs_prev;
    logic [1:0] r_settle;
    logic r_armed;

    logic [FRAME_W-1:0] r_rx;
    logic [DATA_W-1:0]  r_tx;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_oe;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe;
    logic               r_frame_err;

    logic w_sclk_rise, w_sclk_fall, w_ncs_rise;
    logic w_start, w_active, w_full;
    logic w_ev_rise, w_ev_shift, w_ev_over, w_ev_fall;
    logic w_rw, w_addr_ok, w_commit, w_err;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic [FRAME_W-1:0] w_rx_next;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_rd_rw, w_rd_ok, w_rd_load;
    logic [DATA_W-1:0]  w_rd_data;

    // Two-flop synchronisers plus previous-value flops for edge detection; settle tracks pipeline fill after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_copi_s1   <= 1'b0;
            r_copi_s2   <= 1'b0;
            r_ncs_s1    <= 1'b1;
            r_ncs_s2    <= 1'b1;
            r_ncs_prev  <= 1'b1;
            r_settle    <= 2'b00;
        end else begin
            r_sclk_s1   <= SCLK;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_copi_s1   <= COPI;
            r_copi_s2   <= r_copi_s1;
            r_ncs_s1    <= nCS;
            r_ncs_s2    <= r_ncs_s1;
            r_ncs_prev  <= r_ncs_s2;
            r_settle    <= {r_settle[0], 1'b1};
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_prev;
    assign w_ncs_rise  = r_ncs_s2 & ~r_ncs_prev;

    // A frame only starts once nCS has genuinely been seen high since reset.
    assign w_start  = (r_state == ST_IDLE) & r_armed & ~r_ncs_s2;
    assign w_active = (r_state == ST_SHIFT) | w_start;
    assign w_full   = (r_bit_cnt == CNT_FULL);

    // nCS rise wins over any SCLK edge in the same cycle.
    assign w_ev_rise  = w_sclk_rise & w_active & ~w_ncs_rise;
    assign w_ev_shift = w_ev_rise & ~w_full;
    assign w_ev_over  = w_ev_rise & w_full;
    assign w_ev_fall  = w_sclk_fall & (r_state == ST_SHIFT) & r_oe & ~w_ncs_rise;

    assign w_rw      = r_rx[FRAME_W-1];
    assign w_addr    = r_rx[DATA_W +: ADDR_W];
    assign w_data    = r_rx[DATA_W-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W+1)'(NUM_REGS));

    assign w_commit = w_ncs_rise & (r_state == ST_SHIFT) & w_full & w_rw & w_addr_ok;
    assign w_err    = w_ncs_rise & (r_bit_cnt != '0) &
                      (~w_full | (r_state == ST_OVERRUN) | ~w_addr_ok);

    // Read header is judged on the shift value including the bit arriving this edge.
    assign w_rx_next = {r_rx[FRAME_W-2:0], r_copi_s2};
    assign w_rd_addr = w_rx_next[ADDR_W-1:0];
    assign w_rd_rw   = w_rx_next[ADDR_W];
    assign w_rd_ok   = ({1'b0, w_rd_addr} < (ADDR_W+1)'(NUM_REGS));
    assign w_rd_load = w_ev_shift & (r_bit_cnt == CNT_ADDR) & ~w_rd_rw;

    // Read-back mux; out-of-range addresses return zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_ok && (w_rd_addr == ADDR_W'(k))) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: nCS rise always returns to IDLE, an extra SCLK edge on a full frame overruns.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_ev_over) begin
                    w_state_next = ST_OVERRUN;
                end
            end
            ST_OVERRUN: begin
                if (w_ncs_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shift/count, read-back shifter, register commit and the one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
            r_rx        <= '0;
            r_tx        <= '0;
            r_bit_cnt   <= '0;
            r_oe        <= 1'b0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_wr_strobe <= '0;
            r_frame_err <= w_err;
            if (r_settle[1] && r_ncs_s2) begin
                r_armed <= 1'b1;
            end
            if (w_ncs_rise) begin
                r_rx      <= '0;
                r_tx      <= '0;
                r_bit_cnt <= '0;
                r_oe      <= 1'b0;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (w_commit && (w_addr == ADDR_W'(k))) begin
                        r_regs[k]      <= w_data;
                        r_wr_strobe[k] <= 1'b1;
                    end
                end
            end else if (w_ev_over) begin
                r_oe <= 1'b0;
                r_tx <= '0;
            end else begin
                if (w_ev_shift) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_rd_load) begin
                        r_tx <= w_rd_data;
                        r_oe <= 1'b1;
                    end
                end
                if (w_ev_fall) begin
                    r_tx <= r_tx << 1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign CIPO_oe   = r_oe;
    assign CIPO      = r_oe & r_tx[DATA_W-1];
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// tb/tb_spi_regfile_rw.sv - scoreboard bench for spi_regfile_rw at default and wide parameters
module tb_spi_regfile_rw;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] sclk_p = 2'b00;
    logic [1:0] copi_p = 2'b00;
    logic [1:0] ncs_p  = 2'b11;

    logic         cipo0, oe0, err0;
    logic [63:0]  flat0;
    logic [7:0]   stb0;
    logic         cipo1, oe1, err1;
    logic [511:0] flat1;
    logic [31:0]  stb1;

    spi_regfile_rw dut0 (
        .clk(clk), .rst(rst), .COPI(copi_p[0]), .SCLK(sclk_p[0]), .nCS(ncs_p[0]),
        .CIPO(cipo0), .CIPO_oe(oe0), .regs_flat(flat0), .wr_strobe(stb0), .frame_err(err0)
    );

    spi_regfile_rw #(.NUM_REGS(32), .DATA_W(16), .ADDR_W(5)) dut1 (
        .clk(clk), .rst(rst), .COPI(copi_p[1]), .SCLK(sclk_p[1]), .nCS(ncs_p[1]),
        .CIPO(cipo1), .CIPO_oe(oe1), .regs_flat(flat1), .wr_strobe(stb1), .frame_err(err1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  strobe;
        logic         err;
        logic [511:0] regs;
        int           cyc;
    } ev_t;

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          rise_on;
        int          rise_off;
    } rd_t;

    ev_t ev_q0[$], ev_q1[$];
    rd_t rd_q0[$], rd_q1[$];
    logic [15:0] m0 [8];
    logic [15:0] m1 [32];
    int rcnt [2];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] snap(input int inst);
        logic [511:0] s = '0;
        if (inst == 0) begin
            for (int k = 0; k < 8; k++) s[k*8 +: 8] = m0[k][7:0];
        end else begin
            for (int k = 0; k < 32; k++) s[k*16 +: 16] = m1[k];
        end
        return s;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 8; k++) m0[k] = '0;
        for (int k = 0; k < 32; k++) m1[k] = '0;
    endtask

    // One SPI frame; frame-level expectations come from the register-file rules, not from DUT state.
    task automatic send_frame(input int inst, input bit rw, input int addr, input logic [15:0] data,
                              input int nbits, input int rst_at);
        int F = (inst == 0) ? 16 : 22;
        int A = (inst == 0) ? 7 : 5;
        int D = (inst == 0) ? 8 : 16;
        int N = (inst == 0) ? 8 : 32;
        logic [63:0] fr;
        logic [15:0] dmask;
        logic [15:0] rdval;
        bit valid, full, commit, err;
        ev_t e;
        rd_t r;
        dmask = (inst == 0) ? 16'h00FF : 16'hFFFF;
        fr = (64'(rw) << (F - 1)) | (64'(addr) << D) | 64'(data & dmask);
        valid = (addr < N);
        full = (nbits == F);
        rdval = '0;
        if (valid) rdval = (inst == 0) ? m0[addr] : m1[addr];
        if (!rw && nbits >= A + 1 && rst_at < 0) begin
            r.n = ((nbits > F) ? F : nbits) - A;
            r.bits = '0;
            for (int j = 0; j < r.n; j++) begin
                r.bits = (r.bits << 1) | 32'((j < D) ? rdval[D-1-j] : 1'b0);
            end
            r.rise_on = A + 1;
            r.rise_off = (nbits > F) ? F + 1 : nbits;
            if (inst == 0) rd_q0.push_back(r); else rd_q1.push_back(r);
        end
        rcnt[inst] = 0;
        @(negedge clk);
        ncs_p[inst] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi_p[inst] = (i < F) ? fr[F-1-i] : 1'($urandom);
            repeat (3) @(negedge clk);
            sclk_p[inst] = 1'b1;
            rcnt[inst]++;
            repeat (6) @(negedge clk);
            sclk_p[inst] = 1'b0;
            repeat (3) @(negedge clk);
            if (i + 1 == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        commit = rw && full && valid;
        err = (nbits != 0) && (!full || !valid);
        if (rst_at < 0) begin
            if (commit) begin
                if (inst == 0) m0[addr] = data & dmask; else m1[addr] = data;
            end
            if (commit || err) begin
                e.strobe = commit ? (32'd1 << addr) : 32'd0;
                e.err = err;
                e.regs = snap(inst);
                e.cyc = cyc + 3;
                if (inst == 0) ev_q0.push_back(e); else ev_q1.push_back(e);
            end
        end else begin
            reset_model();
        end
        ncs_p[inst] = 1'b1;
        copi_p[inst] = 1'b0;
        repeat (8) @(negedge clk);
        if (inst == 0) chk("pending0", 512'(ev_q0.size() + rd_q0.size()), 512'd0);
        else           chk("pending1", 512'(ev_q1.size() + rd_q1.size()), 512'd0);
    endtask

    // Event monitors: any strobe or frame error must match the next queued expectation.
    ev_t me0, me1;
    always @(negedge clk) begin
        if (!rst) begin
            if (stb0 != 0 || err0) begin
                if (ev_q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event0: strobe=%0h err=%0b expected no event", stb0, err0);
                end else begin
                    me0 = ev_q0.pop_front();
                    chk("strobe0", 512'(stb0), 512'(me0.strobe));
                    chk("frame_err0", 512'(err0), 512'(me0.err));
                    chk("regs0", 512'(flat0), me0.regs);
                    chk("latency0", 512'(cyc), 512'(me0.cyc));
                end
            end
            if (stb1 != 0 || err1) begin
                if (ev_q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event1: strobe=%0h err=%0b expected no event", stb1, err1);
                end else begin
                    me1 = ev_q1.pop_front();
                    chk("strobe1", 512'(stb1), 512'(me1.strobe));
                    chk("frame_err1", 512'(err1), 512'(me1.err));
                    chk("regs1", flat1, me1.regs);
                    chk("latency1", 512'(cyc), 512'(me1.cyc));
                end
            end
            chk("cipo_gate0", 512'(cipo0 & ~oe0), 512'd0);
            chk("cipo_gate1", 512'(cipo1 & ~oe1), 512'd0);
        end
    end

    // Read monitors: capture CIPO just before each SCLK fall while the pad is enabled.
    logic [31:0] cap0, cap1;
    int capn0, capn1, ron0, ron1;
    rd_t mr0, mr1;

    always @(posedge oe0) begin ron0 = rcnt[0]; cap0 = '0; capn0 = 0; end
    always @(posedge oe1) begin ron1 = rcnt[1]; cap1 = '0; capn1 = 0; end
    always @(negedge sclk_p[0]) if (oe0) begin cap0 = (cap0 << 1) | 32'(cipo0); capn0++; end
    always @(negedge sclk_p[1]) if (oe1) begin cap1 = (cap1 << 1) | 32'(cipo1); capn1++; end

    always @(negedge oe0) begin
        if (!rst) begin
            if (rd_q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_read0: bits=%0h expected no read", cap0);
            end else begin
                mr0 = rd_q0.pop_front();
                chk("read_bits0", 512'(cap0), 512'(mr0.bits));
                chk("read_nbits0", 512'(capn0), 512'(mr0.n));
                chk("oe_on_edge0", 512'(ron0), 512'(mr0.rise_on));
                chk("oe_off_edge0", 512'(rcnt[0]), 512'(mr0.rise_off));
            end
        end
    end

    always @(negedge oe1) begin
        if (!rst) begin
            if (rd_q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_read1: bits=%0h expected no read", cap1);
            end else begin
                mr1 = rd_q1.pop_front();
                chk("read_bits1", 512'(cap1), 512'(mr1.bits));
                chk("read_nbits1", 512'(capn1), 512'(mr1.n));
                chk("oe_on_edge1", 512'(ron1), 512'(mr1.rise_on));
                chk("oe_off_edge1", 512'(rcnt[1]), 512'(mr1.rise_off));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    int nbl [13] = '{0, 5, 7, 8, 12, 15, 16, 16, 16, 16, 16, 17, 18};
    int ibl [4]  = '{21, 22, 22, 23};

    initial begin
        reset_model();
        rcnt[0] = 0;
        rcnt[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_regs0", 512'(flat0), 512'd0);
        chk("reset_regs1", flat1, 512'd0);
        chk("reset_strobe0", 512'(stb0), 512'd0);
        chk("reset_err0", 512'(err0), 512'd0);
        chk("reset_oe0", 512'(oe0), 512'd0);
        chk("reset_cipo0", 512'(cipo0), 512'd0);
        chk("reset_oe1", 512'(oe1), 512'd0);

        send_frame(0, 1'b1, 3, 16'h00A5, 16, -1);
        send_frame(0, 1'b1, 5, 16'h005C, 16, -1);
        send_frame(0, 1'b0, 5, 16'($urandom), 16, -1);
        send_frame(0, 1'b1, 8, 16'h0011, 16, -1);
        send_frame(0, 1'b0, 8, 16'h0000, 16, -1);
        send_frame(0, 1'b1, 2, 16'h0066, 15, -1);
        send_frame(0, 1'b1, 2, 16'h0066, 17, -1);
        send_frame(0, 1'b0, 3, 16'h0000, 17, -1);
        send_frame(0, 1'b1, 0, 16'h0000, 0, -1);

        for (int t = 0; t < 30; t++) begin
            send_frame(0, 1'($urandom), $urandom_range(0, 9), 16'($urandom),
                       nbl[$urandom_range(0, 12)], -1);
        end

        send_frame(0, 1'b1, 1, 16'h0077, 16, 9);
        chk("midframe_reset_regs0", 512'(flat0), 512'd0);
        chk("midframe_reset_regs1", flat1, 512'd0);
        send_frame(0, 1'b1, 1, 16'h003C, 16, -1);
        send_frame(0, 1'b0, 1, 16'h0000, 16, -1);

        send_frame(1, 1'b1, 31, 16'hBEEF, 22, -1);
        send_frame(1, 1'b0, 31, 16'h0000, 22, -1);
        send_frame(1, 1'b0, 0, 16'h0000, 22, -1);
        chk("wide_reg0_untouched", 512'(flat1[15:0]), 512'd0);
        for (int t = 0; t < 10; t++) begin
            send_frame(1, 1'($urandom), $urandom_range(0, 31), 16'($urandom),
                       ibl[$urandom_range(0, 3)], -1);
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
